// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, data, optional parity, stop bits paced by baud_tick
`timescale 1ns/1ps
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [1:0]            parity_type,
    output logic                  tx,
    output logic                  parity_bit,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] ordered;
    logic [1:0]            ptype_reg;
    logic [3:0]            bit_cnt, bit_cnt_next;
    logic                  stop_cnt, stop_cnt_next;
    logic                  done_next;
    logic                  accept;
    logic                  data_bit;

    // Holding ready low during the done cycle guarantees one idle clock between frames.
    assign tx_ready = (state == IDLE) && !done;
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        ordered = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ordered[i] = (LSB_FIRST != 0) ? data_reg[i] : data_reg[DATA_WIDTH-1-i];
        end
    end

    assign data_bit = |(ordered & (DATA_WIDTH'(1) << bit_cnt));

    always_comb begin
        case (ptype_reg)
            2'b01:   parity_bit = ~(^data_reg);
            2'b10:   parity_bit = ^data_reg;
            2'b11:   parity_bit = 1'b1;
            default: parity_bit = 1'b0;
        endcase
    end

    always_comb begin
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = data_bit;
            PARITY:  tx = parity_bit;
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = LOAD;
            end
            LOAD: begin
                if (baud_tick) state_next = START;
            end
            START: begin
                if (baud_tick) begin
                    state_next   = DATA;
                    bit_cnt_next = 4'd0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next    = (ptype_reg == 2'b00) ? STOP : PARITY;
                        stop_cnt_next = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_next    = STOP;
                    stop_cnt_next = 1'b0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            data_reg  <= '0;
            ptype_reg <= 2'b00;
            bit_cnt   <= 4'd0;
            stop_cnt  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            done     <= done_next;
            if (accept) begin
                data_reg  <= tx_data;
                ptype_reg <= parity_type;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed bench with a frame-level queue model for uart_tx_framer
`timescale 1ns/1ps
module tb_uart_tx_framer;
    logic       clock = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] parity_type;
    logic       tx_ready_a, tx_a, parity_a, busy_a, done_a;
    logic       tx_ready_b, tx_b, parity_b, busy_b, done_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    always #5 clock = ~clock;

    uart_tx_framer dut_a (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_valid(tx_valid),
        .tx_ready(tx_ready_a), .tx_data(tx_data), .parity_type(parity_type),
        .tx(tx_a), .parity_bit(parity_a), .busy(busy_a), .done(done_a)
    );

    uart_tx_framer #(.DATA_WIDTH(7), .STOP_BITS(2), .LSB_FIRST(0)) dut_b (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_valid(tx_valid),
        .tx_ready(tx_ready_b), .tx_data(tx_data[6:0]), .parity_type(parity_type),
        .tx(tx_b), .parity_bit(parity_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame model for dut_a: a queue of the line levels still to be sent.
    logic m_q[$];
    logic m_idle = 1'b1, m_done = 1'b0, m_ready = 1'b1, m_tx = 1'b1, m_par = 1'b0;
    logic m_acc;

    always @(posedge clock) begin
        m_acc = m_ready && tx_valid;
        if (reset) begin
            m_q.delete();
            m_idle = 1'b1; m_done = 1'b0; m_tx = 1'b1; m_par = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_idle) begin
                if (m_acc) begin
                    case (parity_type)
                        2'b01:   m_par = ($countones(tx_data) % 2) == 0;
                        2'b10:   m_par = ($countones(tx_data) % 2) != 0;
                        2'b11:   m_par = 1'b1;
                        default: m_par = 1'b0;
                    endcase
                    m_q.delete();
                    m_q.push_back(1'b0);
                    for (int i = 0; i < 8; i++) m_q.push_back(tx_data[i]);
                    if (parity_type != 2'b00) m_q.push_back(m_par);
                    m_q.push_back(1'b1);
                    m_idle = 1'b0;
                    m_tx   = 1'b1;
                end
            end else if (baud_tick) begin
                if (m_q.size() > 0) begin
                    m_tx = m_q.pop_front();
                end else begin
                    m_idle = 1'b1; m_done = 1'b1; m_tx = 1'b1;
                end
            end
        end
        m_ready = m_idle && !m_done;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_tx", tx_a, m_tx);
            check("cyc_ready", tx_ready_a, m_ready);
            check("cyc_busy", busy_a, !m_idle);
            check("cyc_done", done_a, m_done);
            check("cyc_parity", parity_a, m_par);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Sends one frame and records tx after every tick until done (or abort via reset).
    task automatic send(input logic [7:0] d, input logic [1:0] p, input bit sel, input bit hold,
                        input bit tick_acc, input int abort_at,
                        output logic [15:0] bits, output int nb);
        int guard;
        bits = '0;
        nb   = 0;
        tx_data = d; parity_type = p; tx_valid = 1'b1;
        guard = 0;
        while (!(sel ? tx_ready_b : tx_ready_a) && guard < 50) begin
            cyc();
            guard++;
        end
        if (guard >= 50) begin
            check("ready_timeout", 0, 1);
            return;
        end
        baud_tick = tick_acc;
        cyc();
        baud_tick = 1'b0;
        if (!hold) tx_valid = 1'b0;
        check("acc_busy", sel ? busy_b : busy_a, 1);
        cyc();
        if (tick_acc) check("acc_tick_tx_idle", tx_a, 1);
        for (int t = 0; t < 30; t++) begin
            baud_tick = 1'b1;
            cyc();
            baud_tick = 1'b0;
            if (sel ? done_b : done_a) return;
            bits[nb] = sel ? tx_b : tx_a;
            nb++;
            if (nb == abort_at) begin
                reset = 1'b1;
                baud_tick = 1'b1;
                cyc();
                reset = 1'b0;
                baud_tick = 1'b0;
                check("abort_tx", tx_a, 1);
                check("abort_ready", tx_ready_a, 1);
                check("abort_busy", busy_a, 0);
                check("abort_done", done_a, 0);
                return;
            end
            cyc();
            cyc();
        end
        check("done_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] bits;
        int          nb;
        reset = 1'b1; baud_tick = 1'b0; tx_valid = 1'b0; tx_data = '0; parity_type = 2'b00;
        cyc();
        cyc();
        chk_en = 1'b1;
        check("rst_tx", tx_a, 1);
        check("rst_ready", tx_ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_parity", parity_a, 0);
        check("rst_tx_b", tx_b, 1);
        reset = 1'b0;
        cyc();

        send(8'h17, 2'b10, 0, 0, 0, -1, bits, nb);
        check("even_bits", bits[10:0], 11'b10000101110);
        check("even_len", nb, 11);
        check("even_parity", parity_a, 0);

        send(8'h17, 2'b01, 0, 0, 0, -1, bits, nb);
        check("odd_slot", bits[9], 1);
        check("odd_parity", parity_a, 1);

        send(8'hAF, 2'b11, 0, 0, 0, -1, bits, nb);
        check("mark_slot", bits[9], 1);
        check("mark_len", nb, 11);

        send(8'hA9, 2'b00, 0, 0, 0, -1, bits, nb);
        check("none_bits", bits[9:0], 10'b1101010010);
        check("none_len", nb, 10);

        send(8'h0F, 2'b10, 0, 1, 0, -1, bits, nb);
        check("b2b_first_bits", bits[10:0], 11'b10000011110);
        tx_data = 8'hBD;
        check("b2b_ready_done_cycle", tx_ready_a, 0);
        cyc();
        check("b2b_ready_after", tx_ready_a, 1);
        check("b2b_idle_gap", busy_a, 0);
        send(8'hBD, 2'b10, 0, 0, 0, -1, bits, nb);
        check("b2b_second_bits", bits[10:0], 11'b10101111010);

        send(8'h17, 2'b10, 0, 0, 1, -1, bits, nb);
        check("tick_acc_bits", bits[10:0], 11'b10000101110);

        send(8'h17, 2'b10, 0, 0, 0, 5, bits, nb);
        check("abort_bit3", bits[4], 0);
        send(8'hA9, 2'b01, 0, 0, 0, -1, bits, nb);
        check("post_reset_bits", bits[10:0], 11'b11101010010);

        send(8'h55, 2'b10, 1, 0, 0, -1, bits, nb);
        check("w7_bits", bits[10:0], 11'b11010101010);
        check("w7_len", nb, 11);
        check("w7_parity", parity_b, 0);

        cyc();
        cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- LSB_FIRST, 1, bit order; 1 sends tx_data[0] first, 0 sends tx_data[DATA_WIDTH-1] first.

REQ-002 The block SHALL have these ports, clock and reset first:
- clock  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clock pulse marking each bit-period boundary.
- tx_valid  input  1  a frame request is present.
- tx_ready  output  1  the block can accept a frame.
- tx_data  input  DATA_WIDTH  payload, sampled at accept.
- parity_type  input  2  parity mode, sampled at accept: 00 none, 01 odd, 10 even, 11 mark.
- tx  output  1  serial line; idle level is 1.
- parity_bit  output  1  parity computed for the frame in flight.
- busy  output  1  a frame is in flight.
- done  output  1  one-clock pulse when a frame completes.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, START, DATA, PARITY and STOP.

REQ-004 tx_ready SHALL be 1 only in IDLE; an accept SHALL occur on a clock edge where tx_valid=1 and tx_ready=1.

REQ-005 On accept, the block SHALL latch tx_data and parity_type and go to LOAD; a baud_tick in the same cycle as accept SHALL be ignored.

REQ-006 In LOAD, the first baud_tick SHALL move the FSM to START and drive tx=0, so that every bit lasts exactly one full tick interval.

REQ-007 Each later baud_tick SHALL advance by one bit:
- START to DATA, sending bit index 0.
- DATA through DATA_WIDTH bits, ordered per LSB_FIRST, with the index counter counting from 0 to DATA_WIDTH-1.
- Then PARITY, or directly to STOP when parity_type=00.
- PARITY to STOP.
- STOP for STOP_BITS tick intervals.

REQ-008 Between ticks, the state and tx SHALL hold.

REQ-009 parity_bit SHALL be computed from the latched values:
- even: XOR of the data bits.
- odd: the inverse of that XOR.
- mark: 1.
- none: 0, and no parity bit is sent.

REQ-010 tx SHALL be 1 during STOP, IDLE and LOAD.

REQ-011 On the baud_tick that ends the last stop bit, the FSM SHALL return to IDLE and done SHALL pulse high for exactly that one cycle.

REQ-012 tx_ready SHALL rise on the cycle after the done pulse, so back-to-back frames are separated by at least one clock of idle.

REQ-013 busy SHALL be 1 in every state except IDLE.

REQ-014 tx_data and parity_type changing after accept SHALL NOT affect the frame in flight.

REQ-015 tx_valid deasserting while busy SHALL have no effect.

REQ-016 A frame SHALL occupy exactly 1 + DATA_WIDTH + P + STOP_BITS tick intervals, where P=0 for mode 00 and P=1 otherwise.

Reset
REQ-017 While reset=1 at a clock edge, the block SHALL set:
- state=IDLE
- tx=1
- tx_ready=1
- busy=0
- done=0
- parity_bit=0
- bit counter=0
- latched registers=0

REQ-018 Reset asserted mid-frame SHALL abort the frame with no done pulse, and tx SHALL be 1 at the next edge.

REQ-019 Reset SHALL take priority over an accept and over baud_tick in the same cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Defaults, tx_data=8'h17, parity_type=10: tx sequence 0,1,1,1,0,1,0,0,0,0(parity),1(stop); parity_bit=0; done pulses once after 11 ticks.
- tx_data=8'h17, parity_type=01: parity bit sent=1. tx_data=8'hAF, parity_type=11: parity bit sent=1. tx_data=8'hA9, parity_type=00: no parity slot; frame is 10 ticks.
- Back-to-back, tx_valid held high, data 8'h0F then 8'hBD: second accept occurs on the cycle after done; both frames are bit-exact; tx_ready=0 throughout each frame.
- baud_tick coincident with the accept cycle: the tick is ignored; tx stays 1 until the next tick; the start bit lasts one full interval.
- Reset asserted during DATA bit 3: next edge shows tx=1, tx_ready=1, busy=0; done is never asserted; a new frame after reset is correct.
- DATA_WIDTH=7, STOP_BITS=2, LSB_FIRST=0, data 7'h55, even parity: MSB first, parity bit=0, two stop ticks, frame is 11 ticks.
